// File: rtl/tdm_pkg.sv
// Shared definitions for the 16-channel TDM receive demux.
//   CHANNELS / SEL_W : channel count and select/slot width
//   tdm_state_e      : frame-assembly FSM states
//   MODE_*           : mode input encodings
//   tdm_ctl_t        : control bundle from the slot counter to the datapath
package tdm_pkg;
  localparam int CHANNELS = 16;
  localparam int SEL_W    = 4;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_TDM  = 1'b1;

  typedef enum logic {HUNT = 1'b0, FILL = 1'b1} tdm_state_e;

  typedef struct packed {
    logic             wr_en;     // write din into shadow[wr_idx]
    logic [SEL_W-1:0] wr_idx;    // shadow entry to write
    logic             commit;    // shadow (with this sample) goes to f
    logic             mode_chg;  // mode differs from registered mode
  } tdm_ctl_t;
endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter and HUNT/FILL frame FSM for TDM mode.
//   clk, rst_n       : clock, async active-low reset
//   mode             : 0 addressed, 1 TDM
//   in_valid, sync   : sample qualifier and frame marker
//   slot             : next expected TDM channel
//   sync_err         : registered strobe, sync seen mid-frame
//   ctl              : shadow write / commit / mode-change controls (combinational)
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             in_valid,
  input  logic             sync,
  output logic [SEL_W-1:0] slot,
  output logic             sync_err,
  output tdm_ctl_t         ctl
);
  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(CHANNELS - 1);

  tdm_state_e       state_q, state_d, state_eff;
  logic [SEL_W-1:0] slot_q, slot_d, slot_eff;
  logic             mode_q, sync_err_q, sync_err_d;

  always_comb begin
    ctl          = '0;
    ctl.mode_chg = (mode != mode_q);
    // A mode change restarts from HUNT in the same cycle, so an accept
    // arriving with the change is evaluated from a clean state.
    state_eff    = ctl.mode_chg ? HUNT : state_q;
    slot_eff     = ctl.mode_chg ? '0 : slot_q;
    state_d      = state_eff;
    slot_d       = slot_eff;
    sync_err_d   = 1'b0;
    ctl.wr_idx   = slot_eff;

    if (mode == MODE_TDM && in_valid) begin
      unique case (state_eff)
        HUNT: begin
          if (sync) begin
            ctl.wr_en  = 1'b1;
            ctl.wr_idx = '0;
            slot_d     = SEL_W'(1);
            state_d    = FILL;
          end
        end
        FILL: begin
          if (sync) begin
            // Early marker: drop the partial frame, this sample is slot 0.
            sync_err_d = (slot_eff != '0);
            ctl.wr_en  = 1'b1;
            ctl.wr_idx = '0;
            slot_d     = SEL_W'(1);
          end else begin
            ctl.wr_en = 1'b1;
            if (slot_eff == LAST_SLOT) begin
              ctl.commit = 1'b1;
              slot_d     = '0;
              state_d    = HUNT;
            end else begin
              slot_d = slot_eff + SEL_W'(1);
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      slot_q     <= '0;
      mode_q     <= MODE_ADDR;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      mode_q     <= mode;
      sync_err_q <= sync_err_d;
    end
  end

  assign slot     = slot_q;
  assign sync_err = sync_err_q;
endmodule

// File: rtl/tdm_demux16.sv
// 1-to-16 receive demux: scatters a WIDTH-bit lane into 16 registered channels.
//   clk, rst_n : clock, async active-low reset
//   mode       : 0 addressed (sw picks channel), 1 TDM (slot counter picks)
//   din        : lane sample, qualified by in_valid
//   sw         : addressed-mode destination channel
//   sync       : TDM frame marker on the slot-0 sample
//   f          : channel outputs, channel k at [k*WIDTH +: WIDTH]
//   out_valid  : strobe, f updated on the previous edge
//   slot       : next expected TDM slot
//   sync_err   : strobe, sync arrived mid-frame
module tdm_demux16
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [WIDTH-1:0]          din,
  input  logic                      in_valid,
  input  logic [SEL_W-1:0]          sw,
  input  logic                      sync,
  output logic [CHANNELS*WIDTH-1:0] f,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          slot,
  output logic                      sync_err
);
  tdm_ctl_t ctl;

  logic [CHANNELS-1:0][WIDTH-1:0] shadow_q, shadow_d;
  logic [CHANNELS-1:0][WIDTH-1:0] f_q, f_d;
  logic                           out_valid_q, out_valid_d;

  tdm_slot_ctr u_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .in_valid (in_valid),
    .sync     (sync),
    .slot     (slot),
    .sync_err (sync_err),
    .ctl      (ctl)
  );

  always_comb begin
    shadow_d    = ctl.mode_chg ? '0 : shadow_q;
    f_d         = f_q;
    out_valid_d = 1'b0;

    if (ctl.wr_en) shadow_d[ctl.wr_idx] = din;

    if (mode == MODE_ADDR && in_valid) begin
      f_d[sw]     = din;
      out_valid_d = 1'b1;
    end else if (ctl.commit) begin
      // shadow_d already carries the slot-15 sample, so all channels land at once.
      f_d         = shadow_d;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q    <= '0;
      f_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      f_q         <= f_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign f         = f_q;
  assign out_valid = out_valid_q;
endmodule

// File: doc/tdm_demux16.md
Name: tdm_demux16

Overview:
- 1-to-16 demultiplexer: the receive-side counterpart of the 16:1 mux.
- Takes a single WIDTH-bit lane and scatters it into 16 registered channel outputs.
- Two modes:
  - Addressed: an external 4-bit select picks the destination channel.
  - TDM: an internal slot counter, aligned by a frame-sync marker, picks the destination. The block assembles whole frames and flags when each frame is complete.
- Sits directly downstream of the mux16 lane.

Parameters:
- WIDTH, 1, bits per channel sample.
- CHANNELS, 16, number of output channels; fixed at 16 for this revision.
- SEL_W, 4, select/slot width; equals log2(CHANNELS).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = addressed, 1 = TDM.
- din  input  WIDTH  lane sample.
- in_valid  input  1  din qualifies this cycle.
- sw  input  SEL_W  destination channel in addressed mode; ignored in TDM.
- sync  input  1  TDM frame marker, coincident with slot-0 sample.
- f  output  CHANNELS*WIDTH  channel outputs; channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  1  one-cycle strobe: f just updated.
- slot  output  SEL_W  current TDM slot (next expected channel).
- sync_err  output  1  one-cycle strobe: sync arrived mid-frame.

Behaviour:
- Reset, asynchronous with rst_n low. All of the following clear to 0 immediately:
  - f, out_valid, slot, sync_err, internal shadow register, internal mode_q.
- Reset mid-frame discards the partial frame.
- All updates occur on the rising clk edge. out_valid and sync_err are registered, so each is high for exactly the cycle after the causing accept.
- An accept is a cycle with in_valid = 1. With in_valid = 0, all state holds and both strobes are 0.
- Addressed mode (mode = 0):
  - On accept, channel sw of f is loaded with din; all other channels hold.
  - out_valid = 1 next cycle.
  - Latency: 1 cycle.
  - slot is held at 0; sync is ignored; sync_err = 0.
- TDM mode (mode = 1). FSM states:
  - HUNT (reset state): wait for an accept with sync = 1.
    - Sync accept: write shadow[0] = din, slot <= 1, go to FILL.
    - Accept without sync: discarded; slot stays 0.
  - FILL, accept with sync = 0:
    - Write shadow[slot] = din and increment slot.
    - When slot = 15: set f <= {din, shadow[14:0]} (all 16 channels commit together), slot <= 0, out_valid = 1 next cycle, go to HUNT.
  - FILL, accept with sync = 1 while slot != 0:
    - sync_err = 1 next cycle; partial frame discarded (f unchanged).
    - This sample is treated as a new slot 0: shadow[0] = din, slot <= 1, stay in FILL.
- Frame boundary: sync on the accept immediately after the slot-15 commit is legal (no error). Back-to-back frames with in_valid held high yield one out_valid per 16 accepts.
- f is never partially updated in TDM; shadow is internal only.
- Mode change: when mode differs from mode_q, the FSM returns to HUNT, slot <= 0, and shadow is cleared. f holds its last value. An accept in that same cycle is processed under the new mode, with the FSM starting from HUNT.
- Arithmetic: the slot counter is SEL_W bits and wraps naturally from 15 to 0 only via commit. No other arithmetic.

Decomposition:
- Shared package tdm_pkg:
  - Constants CHANNELS = 16 and SEL_W = 4.
  - FSM state enum (HUNT, FILL).
  - Mode encodings MODE_ADDR = 0, MODE_TDM = 1.
- One natural sub-module: tdm_slot_ctr.
  - Contains the slot counter, HUNT/FILL FSM and sync_err generation.
  - Outputs slot, a commit strobe and a write-enable.
  - Top level holds shadow, f and the addressed-mode write path.

Test Plan:
- Reset: rst_n low asynchronously mid-frame at slot 7 -> f = 0, slot = 0, out_valid = 0 immediately, without a clock edge. After release, the next sync starts a fresh frame.
- Addressed sweep, mode = 0, WIDTH = 1: drive din = 1 with sw = 0..15 on consecutive cycles, starting from f = 0.
  - Each cycle one more bit of f sets, ending f = 16'hFFFF.
  - out_valid is high 16 consecutive cycles.
  - Then din = 0 with sw = 4'b1010 -> f = 16'hFBFF.
- TDM frame, mode = 1:
  - First frame: sync on the first accept; din sequence 1,0,1,1,0,0,0,0,0,0,0,0,0,0,0,1 for slots 0..15 -> f stays 0 until the commit, then f = 16'h800D with a single out_valid pulse.
  - Second frame: sync on the accept immediately after the commit, no gap, with all din = 0 -> commits f = 16'h0000 16 accepts later; sync_err never asserts.
- in_valid gaps: same frame as above with in_valid low for 3 cycles after slots 4 and 11 -> identical f = 16'h800D. Commit is delayed by 6 cycles; slot holds during the gaps.
- Mid-frame sync: sync at slot 9 -> sync_err pulses once and f is unchanged. The following 15 accepts complete a frame built from the sample taken at that sync plus those 15 samples.
- Hunt and mode switch:
  - Accepts without sync in HUNT -> slot stays 0, no out_valid.
  - Toggling mode 1 -> 0 -> 1 at slot 6 -> slot = 0, f held, and the next frame requires sync.
